// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 codes, FSM state
// encodings, byte-enable constants and small decode helpers.
package lsu_pkg;

  // Loads and stores share encodings for the byte/half/word widths.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [3:0] BE_NONE    = 4'b0000;
  localparam logic [3:0] BE_BYTE0   = 4'b0001;
  localparam logic [3:0] BE_LO_HALF = 4'b0011;
  localparam logic [3:0] BE_HI_HALF = 4'b1100;
  localparam logic [3:0] BE_ALL     = 4'b1111;

  function automatic logic funct3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Only meaningful for legal codes; store widths alias the load widths.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3)
      F3_LH, F3_LHU: return lo[0];
      F3_LW:         return lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-bus interface between the load/store unit (master) and memory (slave).
//   req   : request, held until ready is sampled high
//   we    : write strobe
//   addr  : word-aligned address
//   be    : byte enables
//   wdata : lane-replicated store data
//   rdata : read data, valid with ready
//   ready : access completes this cycle
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (output req, we, addr, be, wdata, input rdata, ready);
  modport slave  (input req, we, addr, be, wdata, output rdata, ready);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
//   st_we/st_funct3/st_addr_lo/st_wdata : operation being accepted
//   be, wdata_lane                      : byte enables and replicated store data
//   ld_funct3/ld_addr_lo                : latched load width and byte offset
//   rdata                               : raw bus read word
//   rdata_ext                           : selected lane, sign/zero extended
module lsu_align
  import lsu_pkg::*;
(
  input  logic        st_we,
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    be         = BE_ALL;
    wdata_lane = '0;
    if (st_we) begin
      case (st_funct3)
        F3_SB: begin
          be         = BE_BYTE0 << st_addr_lo;
          wdata_lane = {4{st_wdata[7:0]}};
        end
        F3_SH: begin
          be         = st_addr_lo[1] ? BE_HI_HALF : BE_LO_HALF;
          wdata_lane = {2{st_wdata[15:0]}};
        end
        default: begin
          be         = BE_ALL;
          wdata_lane = st_wdata;
        end
      endcase
    end
  end

  always_comb begin
    byte_sel = rdata[7:0];
    case (ld_addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = ld_addr_lo[1] ? rdata[31:16] : rdata[15:0];

    case (ld_funct3)
      F3_LB:   rdata_ext = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_ext = {{16{half_sel[15]}}, half_sel};
      F3_LBU:  rdata_ext = {24'h0, byte_sel};
      F3_LHU:  rdata_ext = {16'h0, half_sel};
      default: rdata_ext = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: one byte/half/word load or store per op over a ready-handshaked
// 32-bit bus. Faulting ops (illegal funct3, misaligned) complete without a bus
// access. Optional bus timeout under macro LSU_TIMEOUT_EN.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for op_valid; result flags and op_rdata held at 0
// BUSY  | bus_req high, bus fields stable, waiting for bus_ready
// DONE  | op_done pulse with result flags, then back to IDLE
//
// Ports:
//   clk, rst                 : clock, async active-high reset
//   op_valid/we/funct3/addr/wdata : operation from the execute stage
//   op_stall                 : op_valid & ~op_done (combinational)
//   op_done/rdata/misalign/err : one-cycle completion and result
//   bus                      : lsu_if master port
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  input  logic        op_we,
  input  logic [2:0]  op_funct3,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  output logic        op_stall,
  output logic        op_done,
  output logic [31:0] op_rdata,
  output logic        op_misalign,
  output logic        op_err,
  lsu_if.master       bus
);

  if (2 ** CNT_W <= TIMEOUT_CYCLES) begin : g_bad_cfg
    $error("CNT_W too narrow for TIMEOUT_CYCLES");
  end

  lsu_state_e  state_q, state_d;
  logic        req_q, req_d, we_q, we_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  alo_q, alo_d;
  logic        done_q, done_d, mis_q, mis_d, err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_end;

  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] rdata_ext;

`ifdef LSU_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  lsu_align u_align (
    .st_we      (op_we),
    .st_funct3  (op_funct3),
    .st_addr_lo (op_addr[1:0]),
    .st_wdata   (op_wdata),
    .be         (be_next),
    .wdata_lane (wdata_next),
    .ld_funct3  (f3_q),
    .ld_addr_lo (alo_q),
    .rdata      (bus.rdata),
    .rdata_ext  (rdata_ext)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= BE_NONE;
      wdata_q <= '0;
      f3_q    <= '0;
      alo_q   <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      f3_q    <= f3_d;
      alo_q   <= alo_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef LSU_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    f3_d    = f3_q;
    alo_d   = alo_q;
    done_d  = 1'b0;
    mis_d   = mis_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    bus_end = 1'b0;
`ifdef LSU_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif

    unique case (state_q)
      IDLE: begin
        rdata_d = '0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        if (op_valid) begin
          if (!funct3_legal(op_we, op_funct3)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else if (addr_misaligned(op_funct3, op_addr[1:0])) begin
            mis_d   = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            req_d   = 1'b1;
            we_d    = op_we;
            addr_d  = {op_addr[31:2], 2'b00};
            be_d    = be_next;
            wdata_d = wdata_next;
            f3_d    = op_funct3;
            alo_d   = op_addr[1:0];
`ifdef LSU_TIMEOUT_EN
            cnt_d   = '0;
`endif
            state_d = BUSY;
          end
        end
      end

      BUSY: begin
        // bus_ready takes priority over a coinciding timeout
        if (bus.ready) begin
          bus_end = 1'b1;
          rdata_d = we_q ? '0 : rdata_ext;
        end
`ifdef LSU_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          bus_end = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
        if (bus_end) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          addr_d  = '0;
          be_d    = BE_NONE;
          wdata_d = '0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        rdata_d = '0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req     = req_q;
  assign bus.we      = we_q;
  assign bus.addr    = addr_q;
  assign bus.be      = be_q;
  assign bus.wdata   = wdata_q;

  assign op_done     = done_q;
  assign op_rdata    = rdata_q;
  assign op_misalign = mis_q;
  assign op_err      = err_q;
  assign op_stall    = op_valid & ~done_q;

endmodule
